rk_mac_pe: RTL

//  Pipelined signed MAC processing element for the RK-stage systolic array.

---
 rtl/rk_mac_pe.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rk_mac_pe.sv
// rtl/rk_mac_pe.sv - pipelined signed MAC processing element for the RK-stage systolic array
// Optional PE_SAT_EN: saturating ACC_W additions with a sticky o_ovf flag.

module rk_mac_pe #(
  parameter  int A_W   = 32,
  parameter  int K_W   = 32,
  parameter  int S     = 3,
  localparam int ACC_W = A_W + K_W + $clog2(S) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_clr,
  input  logic                    i_mode,
  input  logic                    i_valid,
  input  logic signed [A_W-1:0]   i_a,
  input  logic signed [K_W-1:0]   i_k,
  input  logic signed [ACC_W-1:0] i_psum,
  output logic signed [K_W-1:0]   o_right,
  output logic                    o_right_valid,
  output logic signed [ACC_W-1:0] o_down,
  output logic                    o_down_valid,
  output logic                    o_ovf
);

  localparam int P_W   = A_W + K_W;
  localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(S - 1);

  logic signed [P_W-1:0]   r_prod;
  logic signed [ACC_W-1:0] r_psum;
  logic                    r_mode;
  logic                    r_v;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_a;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] res;
`ifdef PE_SAT_EN
  logic                    sat_ovf;
`endif

  // k forwarding to the right neighbour ignores i_clr
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_right       <= '0;
      o_right_valid <= 1'b0;
    end else begin
      o_right       <= i_k;
      o_right_valid <= i_valid;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prod <= '0;
      r_psum <= '0;
      r_mode <= 1'b0;
      r_v    <= 1'b0;
    end else if (i_clr) begin
      r_v <= 1'b0;
    end else if (i_valid) begin
      r_prod <= P_W'(i_a) * P_W'(i_k);
      r_psum <= i_psum;
      r_mode <= i_mode;
      r_v    <= 1'b1;
    end else begin
      r_v <= 1'b0;
    end
  end

  // The first beat of an accumulation group starts from zero, not from the stale acc
  always_comb begin
    prod_ext = ACC_W'(r_prod);
    add_a    = r_psum;
    if (r_mode) add_a = (cnt == '0) ? '0 : acc;
    sum = add_a + prod_ext;
    res = sum;
`ifdef PE_SAT_EN
    sat_ovf = (add_a[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != add_a[ACC_W-1]);
    if (sat_ovf) res = add_a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_down       <= '0;
      o_down_valid <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
    end else if (i_clr) begin
      o_down       <= '0;
      o_down_valid <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
    end else if (r_v && !r_mode) begin
      o_down       <= res;
      o_down_valid <= 1'b1;
      cnt          <= '0;
    end else if (r_v) begin
      acc <= res;
      if (cnt == CNT_MAX) begin
        o_down       <= res;
        o_down_valid <= 1'b1;
        cnt          <= '0;
      end else begin
        o_down_valid <= 1'b0;
        cnt          <= cnt + 1'b1;
      end
    end else begin
      o_down_valid <= 1'b0;
    end
  end

`ifdef PE_SAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              o_ovf <= 1'b0;
    else if (i_clr)         o_ovf <= 1'b0;
    else if (r_v && sat_ovf) o_ovf <= 1'b1;
  end
`else
  assign o_ovf = 1'b0;
`endif

endmodule
